// File: rtl/alu_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_pkg
// Shared widths, ALU opcode encodings and helper types for the ID/EX operand
// stage that feeds the 16-bit ALU.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_operand_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int OP_W    = 3;

  // Register 0 is hardwired to zero and is never a forwarding target.
  localparam logic [RADDR_W-1:0] REG_ZERO = 3'd0;

  // ALU opcode encodings.
  localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [OP_W-1:0] ALU_SLL  = 3'b101;
  localparam logic [OP_W-1:0] ALU_SRL  = 3'b110;
  localparam logic [OP_W-1:0] ALU_PASS = 3'b111;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [RADDR_W-1:0] raddr_t;
  typedef logic [OP_W-1:0]    op_t;

  // Control fields carried alongside the operands.
  typedef struct packed {
    raddr_t rd;
    logic   reg_wr;
    logic   mem_rd;
    logic   mem_wr;
    op_t    alu_op;
  } ctrl_t;

  // True when an enabled write port targets the given register index.
  function automatic logic idx_hit(input logic wr, input raddr_t wr_idx, input raddr_t src_idx);
    return wr & (wr_idx == src_idx);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Bundles every non-clock signal of the operand stage: upstream decoded
// instruction handshake, EX/MEM and MEM/WB forwarding sources, flush, and the
// downstream ALU operand/control handshake.
//   slave  : view taken by the stage itself
//   master : view taken by the surrounding pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  // Upstream decoded instruction
  logic   in_valid;
  logic   in_ready;
  raddr_t in_rs1;
  raddr_t in_rs2;
  raddr_t in_rd;
  data_t  in_rdata1;
  data_t  in_rdata2;
  data_t  in_imm;
  logic   in_use_imm;
  op_t    in_alu_op;
  logic   in_reg_wr;
  logic   in_mem_rd;
  logic   in_mem_wr;

  // Forwarding sources
  logic   exm_wr;
  raddr_t exm_rd;
  data_t  exm_data;
  logic   wb_wr;
  raddr_t wb_rd;
  data_t  wb_data;

  logic   flush;

  // Downstream ALU side
  logic   out_valid;
  logic   out_ready;
  data_t  data1;
  data_t  data2;
  op_t    alu_op;
  raddr_t out_rd;
  logic   out_reg_wr;
  logic   out_mem_rd;
  logic   out_mem_wr;
  data_t  out_st_data;
  logic   hazard_stall;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rdata1, in_rdata2, in_imm,
           in_use_imm, in_alu_op, in_reg_wr, in_mem_rd, in_mem_wr,
           exm_wr, exm_rd, exm_data, wb_wr, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, data1, data2, alu_op, out_rd, out_reg_wr,
           out_mem_rd, out_mem_wr, out_st_data, hazard_stall
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rdata1, in_rdata2, in_imm,
           in_use_imm, in_alu_op, in_reg_wr, in_mem_rd, in_mem_wr,
           exm_wr, exm_rd, exm_data, wb_wr, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, data1, data2, alu_op, out_rd, out_reg_wr,
           out_mem_rd, out_mem_wr, out_st_data, hazard_stall
  );

endinterface

// File: rtl/alu_operand_stage_operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_operand_fwd_mux
// Resolves one source operand: register 0 reads as zero, otherwise the EX/MEM
// result wins over the MEM/WB result, which wins over the fallback data.
//   i_rs                 source register index
//   i_rf_data            fallback value (register file read or held operand)
//   i_exm_wr/_rd/_data   EX/MEM forwarding port
//   i_wb_wr/_rd/_data    MEM/WB forwarding port
//   o_data               resolved operand
// ---------------------------------------------------------------------------
module alu_operand_stage_operand_fwd_mux
  import alu_operand_stage_pkg::*;
(
  input  raddr_t i_rs,
  input  data_t  i_rf_data,
  input  logic   i_exm_wr,
  input  raddr_t i_exm_rd,
  input  data_t  i_exm_data,
  input  logic   i_wb_wr,
  input  raddr_t i_wb_rd,
  input  data_t  i_wb_data,
  output data_t  o_data
);

  // Pick the youngest in-flight producer of the source register.
  always_comb begin
    o_data = i_rf_data;
    if (i_rs == REG_ZERO) begin
      o_data = {DATA_W{1'b0}};
    end else if (idx_hit(i_exm_wr, i_exm_rd, i_rs)) begin
      o_data = i_exm_data;
    end else if (idx_hit(i_wb_wr, i_wb_rd, i_rs)) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_rf_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// ID/EX register stage in front of the 16-bit ALU. Accepts a decoded
// instruction on a valid/ready handshake, resolves both operands with
// EX/MEM > MEM/WB > register-file priority, selects the immediate for data2,
// inserts a bubble on a load-use hazard, and supports backpressure and flush.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_operand_stage_if.slave (all handshake, forwarding and outputs)
// ---------------------------------------------------------------------------
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  alu_operand_stage_if.slave   bus
);

  logic   r_valid;
  data_t  r_data1;
  data_t  r_data2;
  data_t  r_st_data;
  ctrl_t  r_ctrl;
  raddr_t r_rs1;
  raddr_t r_rs2;
  logic   r_use_imm;

  data_t  w_in_op1;
  data_t  w_in_op2;
  data_t  w_hold_op1;
  data_t  w_hold_op2;
  logic   w_rd_hit1;
  logic   w_rd_hit2;
  logic   w_hazard;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_hold;

  // Operands of the incoming instruction.
  alu_operand_stage_operand_fwd_mux u_in_op1 (
    .i_rs(bus.in_rs1), .i_rf_data(bus.in_rdata1),
    .i_exm_wr(bus.exm_wr), .i_exm_rd(bus.exm_rd), .i_exm_data(bus.exm_data),
    .i_wb_wr(bus.wb_wr), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_in_op1)
  );

  alu_operand_stage_operand_fwd_mux u_in_op2 (
    .i_rs(bus.in_rs2), .i_rf_data(bus.in_rdata2),
    .i_exm_wr(bus.exm_wr), .i_exm_rd(bus.exm_rd), .i_exm_data(bus.exm_data),
    .i_wb_wr(bus.wb_wr), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_in_op2)
  );

  // Held operands refreshed from producers that complete while stalled.
  // The stored values are the fallback, so no match keeps them unchanged.
  alu_operand_stage_operand_fwd_mux u_hold_op1 (
    .i_rs(r_rs1), .i_rf_data(r_data1),
    .i_exm_wr(bus.exm_wr), .i_exm_rd(bus.exm_rd), .i_exm_data(bus.exm_data),
    .i_wb_wr(bus.wb_wr), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_hold_op1)
  );

  // out_st_data always holds the rs2 register value, even when data2 is the immediate.
  alu_operand_stage_operand_fwd_mux u_hold_op2 (
    .i_rs(r_rs2), .i_rf_data(r_st_data),
    .i_exm_wr(bus.exm_wr), .i_exm_rd(bus.exm_rd), .i_exm_data(bus.exm_data),
    .i_wb_wr(bus.wb_wr), .i_wb_rd(bus.wb_rd), .i_wb_data(bus.wb_data),
    .o_data(w_hold_op2)
  );

  // Load-use detection against the held load, plus the accept/hold decisions.
  // A store needs rs2 as data even when data2 carries the address immediate.
  always_comb begin
    w_rd_hit1  = (r_ctrl.rd == bus.in_rs1);
    w_rd_hit2  = (r_ctrl.rd == bus.in_rs2) & (~bus.in_use_imm | bus.in_mem_wr);
    w_hazard   = bus.in_valid & r_valid & r_ctrl.mem_rd & (r_ctrl.rd != REG_ZERO) &
                 (w_rd_hit1 | w_rd_hit2);
    w_in_ready = (~r_valid | bus.out_ready) & ~w_hazard & ~bus.flush;
    w_accept   = bus.in_valid & w_in_ready;
    w_hold     = r_valid & ~bus.out_ready;
  end

  // Pipeline register: flush beats accept beats hold; otherwise emit a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data1   <= {DATA_W{1'b0}};
      r_data2   <= {DATA_W{1'b0}};
      r_st_data <= {DATA_W{1'b0}};
      r_ctrl    <= '{rd: 3'd0, reg_wr: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, alu_op: 3'd0};
      r_rs1     <= 3'd0;
      r_rs2     <= 3'd0;
      r_use_imm <= 1'b0;
    end else if (bus.flush) begin
      r_valid       <= 1'b0;
      r_ctrl.reg_wr <= 1'b0;
      r_ctrl.mem_rd <= 1'b0;
      r_ctrl.mem_wr <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_data1   <= w_in_op1;
      r_data2   <= bus.in_use_imm ? bus.in_imm : w_in_op2;
      r_st_data <= w_in_op2;
      r_ctrl    <= '{rd: bus.in_rd, reg_wr: bus.in_reg_wr, mem_rd: bus.in_mem_rd,
                     mem_wr: bus.in_mem_wr, alu_op: bus.in_alu_op};
      r_rs1     <= bus.in_rs1;
      r_rs2     <= bus.in_rs2;
      r_use_imm <= bus.in_use_imm;
    end else if (w_hold) begin
      r_data1   <= w_hold_op1;
      r_data2   <= r_use_imm ? r_data2 : w_hold_op2;
      r_st_data <= w_hold_op2;
    end else begin
      r_valid       <= 1'b0;
      r_ctrl.reg_wr <= 1'b0;
      r_ctrl.mem_rd <= 1'b0;
      r_ctrl.mem_wr <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.hazard_stall = w_hazard;
  assign bus.out_valid    = r_valid;
  assign bus.data1        = r_data1;
  assign bus.data2        = r_data2;
  assign bus.out_st_data  = r_st_data;
  assign bus.alu_op       = r_ctrl.alu_op;
  assign bus.out_rd       = r_ctrl.rd;
  assign bus.out_reg_wr   = r_ctrl.reg_wr;
  assign bus.out_mem_rd   = r_ctrl.mem_rd;
  assign bus.out_mem_wr   = r_ctrl.mem_wr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed scenarios followed by randomized traffic. A slot-level reference
// model predicts what the stage presents each cycle and queues it; a monitor
// pops one prediction per cycle and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clk;
  logic rst;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic        use_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  op;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] st;
  } item_t;

  item_t exp_q[$];
  bit    m_valid;
  item_t m_item;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Architectural value of register s as seen this cycle.
  function automatic logic [15:0] res(input logic [2:0] s, input logic [15:0] rf);
    if (s == 3'd0) return 16'h0000;
    if (bus.exm_wr && bus.exm_rd == s) return bus.exm_data;
    if (bus.wb_wr && bus.wb_rd == s) return bus.wb_data;
    return rf;
  endfunction

  // Reference model: decides what occupies the output slot after each edge.
  always @(negedge clk) begin
    bit hz;
    bit rdy;
    #2;
    if (rst) begin
      m_valid = 1'b0;
      m_item  = '{default: '0};
    end else begin
      hz = bus.in_valid && m_valid && m_item.mem_rd && (m_item.rd != 3'd0) &&
           ((m_item.rd == bus.in_rs1) ||
            ((m_item.rd == bus.in_rs2) && (!bus.in_use_imm || bus.in_mem_wr)));
      rdy = (!m_valid || bus.out_ready) && !hz && !bus.flush;
      chk("hazard_stall", 32'(bus.hazard_stall), 32'(hz));
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      if (bus.flush) begin
        m_valid = 1'b0;
      end else if (bus.in_valid && rdy) begin
        m_valid        = 1'b1;
        m_item.rs1     = bus.in_rs1;
        m_item.rs2     = bus.in_rs2;
        m_item.rd      = bus.in_rd;
        m_item.use_imm = bus.in_use_imm;
        m_item.reg_wr  = bus.in_reg_wr;
        m_item.mem_rd  = bus.in_mem_rd;
        m_item.mem_wr  = bus.in_mem_wr;
        m_item.op      = bus.in_alu_op;
        m_item.d1      = res(bus.in_rs1, bus.in_rdata1);
        m_item.st      = res(bus.in_rs2, bus.in_rdata2);
        m_item.d2      = bus.in_use_imm ? bus.in_imm : m_item.st;
      end else if (m_valid && !bus.out_ready) begin
        m_item.d1 = res(m_item.rs1, m_item.d1);
        m_item.st = res(m_item.rs2, m_item.st);
        if (!m_item.use_imm) m_item.d2 = m_item.st;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (m_valid) exp_q.push_back(m_item);
  end

  // Monitor: one prediction per presented cycle, compared field by field.
  always @(negedge clk) begin
    item_t e;
    bit    exp_v;
    #1;
    exp_v = (exp_q.size() != 0);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    if (exp_v) begin
      e = exp_q.pop_front();
      if (bus.out_valid === 1'b1) begin
        chk("data1", 32'(bus.data1), 32'(e.d1));
        chk("data2", 32'(bus.data2), 32'(e.d2));
        chk("out_st_data", 32'(bus.out_st_data), 32'(e.st));
        chk("alu_op", 32'(bus.alu_op), 32'(e.op));
        chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
        chk("ctrl", 32'({bus.out_reg_wr, bus.out_mem_rd, bus.out_mem_wr}),
            32'({e.reg_wr, e.mem_rd, e.mem_wr}));
      end
    end
    if (bus.out_valid !== 1'b1) begin
      chk("bubble_ctrl", 32'({bus.out_reg_wr, bus.out_mem_rd, bus.out_mem_wr}), 32'(0));
    end
  end

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_rs1     = 3'd0;
    bus.in_rs2     = 3'd0;
    bus.in_rd      = 3'd0;
    bus.in_rdata1  = 16'h0000;
    bus.in_rdata2  = 16'h0000;
    bus.in_imm     = 16'h0000;
    bus.in_use_imm = 1'b0;
    bus.in_alu_op  = ALU_ADD;
    bus.in_reg_wr  = 1'b0;
    bus.in_mem_rd  = 1'b0;
    bus.in_mem_wr  = 1'b0;
    bus.exm_wr     = 1'b0;
    bus.exm_rd     = 3'd0;
    bus.exm_data   = 16'h0000;
    bus.wb_wr      = 1'b0;
    bus.wb_rd      = 3'd0;
    bus.wb_data    = 16'h0000;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic rand_cycle();
    bus.in_valid   = ($urandom_range(0, 9) < 7);
    bus.in_rs1     = 3'($urandom_range(0, 7));
    bus.in_rs2     = 3'($urandom_range(0, 7));
    bus.in_rd      = 3'($urandom_range(0, 7));
    bus.in_rdata1  = 16'($urandom);
    bus.in_rdata2  = 16'($urandom);
    bus.in_imm     = 16'($urandom);
    bus.in_use_imm = ($urandom_range(0, 9) < 3);
    bus.in_alu_op  = 3'($urandom_range(0, 7));
    bus.in_reg_wr  = ($urandom_range(0, 1) == 1);
    bus.in_mem_rd  = ($urandom_range(0, 3) == 0);
    bus.in_mem_wr  = ($urandom_range(0, 6) == 0);
    bus.exm_wr     = ($urandom_range(0, 9) < 4);
    bus.exm_rd     = 3'($urandom_range(0, 7));
    bus.exm_data   = 16'($urandom);
    bus.wb_wr      = ($urandom_range(0, 9) < 4);
    bus.wb_rd      = 3'($urandom_range(0, 7));
    bus.wb_data    = 16'($urandom);
    bus.flush      = ($urandom_range(0, 19) == 0);
    bus.out_ready  = ($urandom_range(0, 9) < 7);
    rst            = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    // Reset values after two reset edges
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_data1", 32'(bus.data1), 32'(0));
    chk("rst_data2", 32'(bus.data2), 32'(0));
    chk("rst_st_data", 32'(bus.out_st_data), 32'(0));
    chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
    chk("rst_out_rd", 32'(bus.out_rd), 32'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Forwarding priority: EX/MEM beats MEM/WB beats register file
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd3; bus.in_rs2 = 3'd1;
    bus.in_rdata1 = 16'h3333; bus.in_rdata2 = 16'h0042;
    bus.exm_wr = 1'b1; bus.exm_rd = 3'd3; bus.exm_data = 16'h1111;
    bus.wb_wr = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 16'h2222;
    bus.in_rd = 3'd4; bus.in_reg_wr = 1'b1; bus.in_alu_op = ALU_ADD;
    @(negedge clk);
    chk("fwd_prio_data1", 32'(bus.data1), 32'h1111);
    chk("fwd_prio_data2", 32'(bus.data2), 32'h0042);
    idle();

    // Register 0 ignores forwarding; immediate replaces data2
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd0; bus.in_rdata1 = 16'h1234;
    bus.exm_wr = 1'b1; bus.exm_rd = 3'd0; bus.exm_data = 16'hBEEF;
    bus.in_use_imm = 1'b1; bus.in_imm = 16'hFFF0;
    bus.in_rs2 = 3'd5; bus.in_rdata2 = 16'h0505; bus.in_alu_op = ALU_SUB;
    @(negedge clk);
    chk("r0_data1", 32'(bus.data1), 32'h0000);
    chk("imm_data2", 32'(bus.data2), 32'hFFF0);
    chk("imm_st_data", 32'(bus.out_st_data), 32'h0505);
    idle();

    // Load-use: load to r2, then a consumer of r2
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; bus.in_rd = 3'd2;
    bus.in_mem_rd = 1'b1; bus.in_reg_wr = 1'b1;
    bus.in_use_imm = 1'b1; bus.in_imm = 16'h0004;
    @(negedge clk);
    chk("ld_out_mem_rd", 32'(bus.out_mem_rd), 32'(1));
    idle();
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd2; bus.in_rs2 = 3'd4;
    bus.in_rdata1 = 16'hDEAD; bus.in_rdata2 = 16'h0404;
    bus.in_rd = 3'd5; bus.in_reg_wr = 1'b1;
    #1;
    chk("lu_hazard", 32'(bus.hazard_stall), 32'(1));
    chk("lu_in_ready", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    chk("lu_bubble", 32'(bus.out_valid), 32'(0));
    bus.wb_wr = 1'b1; bus.wb_rd = 3'd2; bus.wb_data = 16'h5A5A;
    #1;
    chk("lu_release_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    chk("lu_issue_valid", 32'(bus.out_valid), 32'(1));
    chk("lu_wb_data1", 32'(bus.data1), 32'h5A5A);
    idle();

    // Backpressure with a MEM/WB refresh of the held rs2
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd1; bus.in_rs2 = 3'd6;
    bus.in_rdata1 = 16'h0101; bus.in_rdata2 = 16'h0606;
    bus.in_rd = 3'd3; bus.in_reg_wr = 1'b1; bus.in_alu_op = ALU_XOR;
    @(negedge clk);
    idle();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_rs1 = 3'd7; bus.in_rdata1 = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      @(negedge clk);
      chk("bp_data1", 32'(bus.data1), 32'h0101);
      chk("bp_data2", 32'(bus.data2), 32'h0606);
      chk("bp_alu_op", 32'(bus.alu_op), 32'(ALU_XOR));
    end
    bus.wb_wr = 1'b1; bus.wb_rd = 3'd6; bus.wb_data = 16'h00AA;
    @(negedge clk);
    chk("bp_refresh_data2", 32'(bus.data2), 32'h00AA);
    chk("bp_refresh_data1", 32'(bus.data1), 32'h0101);
    bus.wb_wr = 1'b0;

    // Flush while holding with a new instruction offered
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
    idle();
    @(negedge clk);
    chk("flush_not_issued", 32'(bus.out_valid), 32'(0));

    // Randomized traffic
    repeat (1500) begin
      @(negedge clk);
      rand_cycle();
    end

    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (4) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
